// File: rtl/bnn_vote_accumulator_pkg.sv
// Shared types and helpers for the BNN vote accumulator: class-vector
// geometry, the window FSM state type and saturating/one-hot helpers.
package bnn_pkg;

  // One vote bit per layer-2 neuron.
  localparam int NUM_CLASSES = 4;
  localparam int CLASS_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  // Working width of the saturating helper; callers zero-extend into it.
  localparam int SAT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } vote_state_t;

  // Increment by one unless the value has already reached the limit.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] limit);
    return (value >= limit) ? value : value + SAT_W'(1);
  endfunction

  // True when exactly one class bit is set.
  function automatic logic is_onehot(input logic [NUM_CLASSES-1:0] vec);
    return (vec != '0) && ((vec & (vec - NUM_CLASSES'(1))) == '0);
  endfunction

endpackage

// File: rtl/bnn_vote_accumulator_if.sv
// Sample/result bus between the BNN core (master) and the vote
// accumulator (slave). rej_cnt exists only with BNN_VOTE_ONEHOT_EN.
interface bnn_vote_if
  import bnn_pkg::*;
#(
  parameter int CNT_W = 5
) ();

  logic                   ena;
  logic                   clear;
  logic                   in_valid;
  logic [NUM_CLASSES-1:0] in_vec;
  logic                   in_ready;
  logic                   out_valid;
  logic [CLASS_W-1:0]     out_class;
  logic [CNT_W-1:0]       out_count;
  logic                   out_tie;
  logic                   busy;
`ifdef BNN_VOTE_ONEHOT_EN
  logic [CNT_W-1:0]       rej_cnt;
`endif

  modport master (
    output ena, clear, in_valid, in_vec,
`ifdef BNN_VOTE_ONEHOT_EN
    input  rej_cnt,
`endif
    input  in_ready, out_valid, out_class, out_count, out_tie, busy
  );

  modport slave (
    input  ena, clear, in_valid, in_vec,
`ifdef BNN_VOTE_ONEHOT_EN
    output rej_cnt,
`endif
    output in_ready, out_valid, out_class, out_count, out_tie, busy
  );

endinterface

// File: rtl/bnn_vote_accumulator_argmax.sv
// Combinational argmax over the per-class vote counters. Lowest index wins
// a tie; tie is raised when two or more counters equal the maximum.
module bnn_argmax
  import bnn_pkg::*;
#(
  parameter int N     = NUM_CLASSES,
  parameter int W     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0][W-1:0] cnt,
  output logic [IDX_W-1:0]    idx,
  output logic [W-1:0]        max_val,
  output logic                tie
);

  logic [IDX_W:0] hits;

  // Comparator chain: strictly-greater keeps the earliest maximum.
  always_comb begin
    // NOTE: every output gets a default before the loops, so no path can leave one unassigned and infer a latch.
    idx     = '0;
    max_val = cnt[0];
    hits    = '0;
    for (int i = 1; i < N; i++) begin
      if (cnt[i] > max_val) begin
        max_val = cnt[i];
        idx     = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (cnt[i] == max_val) hits = hits + (IDX_W + 1)'(1);
    end
    tie = (hits >= (IDX_W + 1)'(2));
  end

endmodule

// File: rtl/bnn_vote_accumulator.sv
// BNN vote accumulator: counts per-class votes over WINDOW accepted samples
// and emits argmax / max count / tie once per window.
// Optional macro BNN_VOTE_ONEHOT_EN: only one-hot samples vote; other
// accepted samples are counted in rej_cnt instead.
module bnn_vote_accumulator
  import bnn_pkg::*;
#(
  parameter int CNT_W  = 5,
  parameter int WINDOW = 16
) (
  input logic      clk,
  input logic      reset,
  bnn_vote_if.slave bus
);

  localparam logic [SAT_W-1:0] CNT_MAX  = SAT_W'((1 << CNT_W) - 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  vote_state_t                        state;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]                   sample_cnt;
  logic                               accept;
  logic                               vote_ok;

  logic                               out_valid_q;
  logic [CLASS_W-1:0]                 out_class_q;
  logic [CNT_W-1:0]                   out_count_q;
  logic                               out_tie_q;

  logic [CLASS_W-1:0]                 win_idx;
  logic [CNT_W-1:0]                   win_max;
  logic                               win_tie;

  // Upstream may only hand over a sample outside the single RESULT cycle.
  assign bus.in_ready = (state != RESULT);
  assign bus.busy     = (state != IDLE);
  assign accept       = bus.ena & bus.in_valid & bus.in_ready & ~bus.clear;

  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_count = out_count_q;
  assign bus.out_tie   = out_tie_q;

`ifdef BNN_VOTE_ONEHOT_EN
  logic [CNT_W-1:0] rej_acc;
  logic [CNT_W-1:0] rej_q;

  assign vote_ok     = is_onehot(bus.in_vec);
  assign bus.rej_cnt = rej_q;

  // Rejected-sample counter, cleared and published with the vote counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rej_acc <= '0;
      rej_q   <= '0;
    end else if (bus.clear) begin
      rej_acc <= '0;
    end else if (state == RESULT) begin
      rej_q   <= rej_acc;
      rej_acc <= '0;
    end else if (accept && !vote_ok) begin
      rej_acc <= CNT_W'(sat_inc(SAT_W'(rej_acc), CNT_MAX));
    end
  end
`else
  assign vote_ok = 1'b1;
`endif

  bnn_argmax #(
    .N (NUM_CLASSES),
    .W (CNT_W)
  ) u_argmax (
    .cnt     (cnt),
    .idx     (win_idx),
    .max_val (win_max),
    .tie     (win_tie)
  );

  // Window FSM with vote counters and registered result outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every branch reads the pre-edge value of state and counters.
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sample_cnt  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_count_q <= '0;
      out_tie_q   <= 1'b0;
    end else if (bus.clear) begin
      // Flush: a pending result is dropped, published outputs stay put.
      state       <= IDLE;
      cnt         <= '0;
      sample_cnt  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
              if (vote_ok && bus.in_vec[i])
                cnt[i] <= CNT_W'(sat_inc(SAT_W'(cnt[i]), CNT_MAX));
            end
            sample_cnt <= sample_cnt + CNT_W'(1);
            state      <= (sample_cnt == LAST_IDX) ? RESULT : ACCUM;
          end
        end
        RESULT: begin
          // Completes regardless of ena.
          out_class_q <= win_idx;
          out_count_q <= win_max;
          out_tie_q   <= win_tie;
          out_valid_q <= 1'b1;
          cnt         <= '0;
          sample_cnt  <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_vote_accumulator.sv
// Self-checking bench for bnn_vote_accumulator. Two instances: the default
// geometry (CNT_W=5, WINDOW=16) and a narrow one (CNT_W=4, WINDOW=15).
// Expected results are queued at stimulus time and popped by per-DUT
// monitors on each out_valid pulse. Honours BNN_VOTE_ONEHOT_EN.
module tb_bnn_vote_accumulator;
  import bnn_pkg::*;

  typedef struct {
    logic [1:0] cls;
    logic [4:0] count;
    logic       tie;
    logic [4:0] rej;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bnn_vote_if #(.CNT_W(5)) bus0 ();
  bnn_vote_if #(.CNT_W(4)) bus1 ();

  bnn_vote_accumulator #(.CNT_W(5), .WINDOW(16)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  bnn_vote_accumulator #(.CNT_W(4), .WINDOW(15)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;
  int   checks = 0;
  int   errors = 0;
  logic prev0  = 1'b0;
  logic prev1  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int cls, input int count, input int tie, input int rej);
    exp_t e;
    e.cls   = 2'(cls);
    e.count = 5'(count);
    e.tie   = 1'(tie);
    e.rej   = 5'(rej);
    return e;
  endfunction

  // Scoreboard monitor for the default instance.
  always @(negedge clk) begin
    if (reset) begin
      prev0 = 1'b0;
    end else begin
      if (bus0.out_valid) begin
        check("dut0 pulse one cycle", 32'(prev0), 32'd0);
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut0 unexpected out_valid: class %0d count %0d, want none",
                   bus0.out_class, bus0.out_count);
        end else begin
          e0 = q0.pop_front();
          check("dut0 out_class", 32'(bus0.out_class), 32'(e0.cls));
          check("dut0 out_count", 32'(bus0.out_count), 32'(e0.count));
          check("dut0 out_tie",   32'(bus0.out_tie),   32'(e0.tie));
`ifdef BNN_VOTE_ONEHOT_EN
          check("dut0 rej_cnt",   32'(bus0.rej_cnt),   32'(e0.rej));
`endif
        end
      end
      prev0 = bus0.out_valid;
    end
  end

  // Scoreboard monitor for the narrow instance.
  always @(negedge clk) begin
    if (reset) begin
      prev1 = 1'b0;
    end else begin
      if (bus1.out_valid) begin
        check("dut1 pulse one cycle", 32'(prev1), 32'd0);
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut1 unexpected out_valid: class %0d count %0d, want none",
                   bus1.out_class, bus1.out_count);
        end else begin
          e1 = q1.pop_front();
          check("dut1 out_class", 32'(bus1.out_class), 32'(e1.cls));
          check("dut1 out_count", 32'(bus1.out_count), 32'(e1.count));
          check("dut1 out_tie",   32'(bus1.out_tie),   32'(e1.tie));
`ifdef BNN_VOTE_ONEHOT_EN
          check("dut1 rej_cnt",   32'(bus1.rej_cnt),   32'(e1.rej));
`endif
        end
      end
      prev1 = bus1.out_valid;
    end
  end

  // Present n samples of vec to dut0; returns 1 time unit after the last accept edge.
  task automatic send0(input logic [3:0] vec, input int n);
    for (int k = 0; k < n; k++) begin
      int   guard = 0;
      logic took  = 1'b0;
      bus0.in_valid = 1'b1;
      bus0.in_vec   = vec;
      while (!took) begin
        @(negedge clk);
        took = bus0.in_ready && bus0.ena && !bus0.clear;
        @(posedge clk);
        #1;
        guard++;
        if (!took && guard > 8) begin
          check("dut0 in_ready timeout", 32'(bus0.in_ready), 32'd1);
          break;
        end
      end
    end
    bus0.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [3:0] vec, input int n);
    for (int k = 0; k < n; k++) begin
      int   guard = 0;
      logic took  = 1'b0;
      bus1.in_valid = 1'b1;
      bus1.in_vec   = vec;
      while (!took) begin
        @(negedge clk);
        took = bus1.in_ready && bus1.ena && !bus1.clear;
        @(posedge clk);
        #1;
        guard++;
        if (!took && guard > 8) begin
          check("dut1 in_ready timeout", 32'(bus1.in_ready), 32'd1);
          break;
        end
      end
    end
    bus1.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", checks);
    $fatal(1);
  end

  initial begin
    bus0.ena = 1'b1; bus0.clear = 1'b0; bus0.in_valid = 1'b0; bus0.in_vec = '0;
    bus1.ena = 1'b1; bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.in_vec = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("reset out_valid", 32'(bus0.out_valid), 32'd0);
    check("reset out_class", 32'(bus0.out_class), 32'd0);
    check("reset out_count", 32'(bus0.out_count), 32'd0);
    check("reset out_tie",   32'(bus0.out_tie),   32'd0);
    check("reset busy",      32'(bus0.busy),      32'd0);
    check("reset in_ready",  32'(bus0.in_ready),  32'd1);
    check("dut1 reset busy", 32'(bus1.busy),      32'd0);
    @(posedge clk);
    #1;

    // Single class window with exact result timing.
    q0.push_back(mk(2, 16, 0, 0));
    send0(4'b0100, 16);
    @(negedge clk);
    check("result cycle in_ready", 32'(bus0.in_ready),  32'd0);
    check("result cycle busy",     32'(bus0.busy),      32'd1);
    check("result cycle no valid", 32'(bus0.out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("valid two cycles after last", 32'(bus0.out_valid), 32'd1);
    check("idle after result busy",      32'(bus0.busy),      32'd0);
    check("idle after result in_ready",  32'(bus0.in_ready),  32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("valid drops",  32'(bus0.out_valid), 32'd0);
    check("class holds",  32'(bus0.out_class), 32'd2);
    @(posedge clk); #1;

    // Two-way tie: lowest index wins.
    q0.push_back(mk(0, 8, 1, 0));
    send0(4'b0001, 8);
    send0(4'b0010, 8);
    idle(4);

    // Mid-window clear drops the partial window.
    send0(4'b0100, 10);
    bus0.clear = 1'b1;
    @(posedge clk); #1;
    bus0.clear = 1'b0;
    @(negedge clk);
    check("clear -> idle",       32'(bus0.busy),      32'd0);
    check("clear keeps class",   32'(bus0.out_class), 32'd0);
    check("clear keeps tie",     32'(bus0.out_tie),   32'd1);
    @(posedge clk); #1;
    q0.push_back(mk(3, 16, 0, 0));
    send0(4'b1000, 16);
    idle(4);

    // Clear during RESULT discards the pending result.
    send0(4'b0001, 16);
    bus0.clear = 1'b1;
    @(posedge clk); #1;
    bus0.clear = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("clear in RESULT no valid", 32'(bus0.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("discard keeps class", 32'(bus0.out_class), 32'd3);
    check("discard keeps count", 32'(bus0.out_count), 32'd16);
    check("discard busy",        32'(bus0.busy),      32'd0);
    @(posedge clk); #1;

    // ena low mid-window freezes, ena low in RESULT still publishes.
    q0.push_back(mk(1, 16, 0, 0));
    send0(4'b0010, 8);
    bus0.ena      = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in_vec   = 4'b0010;
    repeat (5) begin
      @(negedge clk);
      check("ena low busy",     32'(bus0.busy),      32'd1);
      check("ena low no valid", 32'(bus0.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    bus0.in_valid = 1'b0;
    bus0.ena      = 1'b1;
    send0(4'b0010, 8);
    bus0.ena = 1'b0;
    @(negedge clk);
    check("ena low RESULT in_ready", 32'(bus0.in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ena low RESULT completes", 32'(bus0.out_valid), 32'd1);
    @(posedge clk); #1;
    bus0.ena = 1'b1;

    // Continuous stream: in_ready low only in each RESULT cycle.
`ifdef BNN_VOTE_ONEHOT_EN
    q0.push_back(mk(0, 0, 1, 16));
    q0.push_back(mk(0, 0, 1, 16));
`else
    q0.push_back(mk(0, 16, 1, 0));
    q0.push_back(mk(0, 16, 1, 0));
`endif
    bus0.in_valid = 1'b1;
    bus0.in_vec   = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check($sformatf("stream in_ready c%0d", c), 32'(bus0.in_ready),
            (c == 16 || c == 33) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
    end
    bus0.in_valid = 1'b0;
    // Third window already holds 6 samples; finish it.
`ifdef BNN_VOTE_ONEHOT_EN
    q0.push_back(mk(0, 0, 1, 16));
`else
    q0.push_back(mk(0, 16, 1, 0));
`endif
    send0(4'b1111, 10);
    idle(4);

`ifdef BNN_VOTE_ONEHOT_EN
    // Only one-hot samples vote.
    q0.push_back(mk(1, 8, 0, 8));
    for (int k = 0; k < 8; k++) begin
      send0(4'b0011, 1);
      send0(4'b0010, 1);
    end
    idle(4);
`endif

    // Narrow instance: counts top out at 2^CNT_W-1 = WINDOW = 15.
    q1.push_back(mk(0, 15, 0, 0));
    send1(4'b0001, 15);
`ifdef BNN_VOTE_ONEHOT_EN
    q1.push_back(mk(0, 0, 1, 15));
`else
    q1.push_back(mk(0, 15, 1, 0));
`endif
    send1(4'b0011, 15);
    idle(5);

    check("dut0 results drained", 32'(q0.size()), 32'd0);
    check("dut1 results drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
